ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- Parametrised AHB-Lite slave fronting an internal word-addressed SRAM array.
- Supports configurable data width, memory depth and wait-state insertion.
- Supports byte, halfword and word writes with byte-lane enables.
- Issues the two-cycle ERROR response for illegal accesses.
- Sits behind the AHB interconnect decoder, driven by hsel, and serves as the standard memory target for the AHB UVM environment.

Parameters:
- DATA_W, 32: bus data width; legal values 32 or 64.
- ADDR_W, 32: haddr width.
- DEPTH, 1024: number of DATA_W-bit words; byte capacity is DEPTH*DATA_W/8.
- WAIT_STATES, 0: number of hreadyout-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hresten  input  1  synchronous, active-high reset.
- hsel  input  1  slave select from decoder.
- haddr  input  ADDR_W  address-phase byte address.
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  input  1  1 = write.
- hsize  input  3  transfer size, bytes = 2**hsize.
- hburst  input  3  burst type; accepted, not used (master supplies every address).
- hprot  input  4  ignored.
- hmastlock  input  1  ignored.
- hready  input  1  bus-level ready; address phase is valid only when high.
- hwdata  input  DATA_W  write data, valid in the data phase.
- hrdata  output  DATA_W  read data.
- hreadyout  output  1  slave ready.
- hresp  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (hresten=1 at a rising edge):
  - state goes to IDLE; hreadyout=1, hresp=0, hrdata=0; wait counter cleared.
  - Memory contents are not cleared.
  - Reset mid-transfer abandons the transfer; no write is committed.
- Accept: the address phase is captured at an edge when hsel & hready & htrans[1]. Registers captured: addr_q, write_q, size_q, lane offset = haddr[log2(DATA_W/8)-1:0].
- Illegal access: any of the following forces the ERROR path, and memory is never written:
  - byte address >= DEPTH*DATA_W/8;
  - 2**hsize > DATA_W/8;
  - haddr not aligned to 2**hsize.
- IDLE, BUSY, or hsel=0 transfers: zero-wait OKAY; no state change.
- States:
  - IDLE: hreadyout=1, hresp=0. A legal accept goes to DATA with cnt=WAIT_STATES. An illegal accept goes to ERR1.
  - DATA:
    - If cnt>0: hreadyout=0, cnt decrements each cycle.
    - If cnt==0: hreadyout=1, hresp=0, and the transfer completes this cycle.
    - On the completing edge: a write commits hwdata to the enabled byte lanes. Then a new legal accept reloads DATA, an illegal accept goes to ERR1, and no accept goes to IDLE.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. Accept rules are the same as for completion from DATA.
- Read data:
  - During a read data phase, hrdata = mem[addr_q] combinationally, with the full word returned and the master selecting lanes.
  - hrdata=0 in every other cycle.
  - Because writes commit at the end of their data phase, a back-to-back write then read to the same address returns the new data.
- Byte enables: size 0 enables 1 lane at the offset; size 1 enables 2 lanes; size 2 enables 4 lanes; size 3 (DATA_W=64 only) enables all 8 lanes.
- Word index = addr_q >> log2(DATA_W/8); no wrap-around.
- Address phases presented while hreadyout=0 are ignored, because hready is low.

Test Plan:
- Reset, then DATA_W=32 WAIT_STATES=0: write word 0xDEADBEEF at 0x10, then read 0x10 back-to-back -> both data phases complete in one cycle each; read returns 0xDEADBEEF with hresp=0.
- Byte writes 0x11 to 0x21 and halfword write 0xAABB to 0x22 over the initial word 0x00000000 at 0x20 -> read of 0x20 returns 0xAABB1100.
- WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, then high with valid data; next NONSEQ issued on the completing cycle is accepted.
- Read at byte address DEPTH*4 (0x1000 when DEPTH=1024) -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); a subsequent legal read returns OKAY.
- Misaligned halfword write to 0x31 -> two-cycle ERROR; a following read of 0x30 shows the word unchanged.
- Assert hresten during the 2nd wait cycle of a write with WAIT_STATES=3 -> next cycle hreadyout=1, hresp=0; the target word is unchanged.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a word-addressed internal SRAM.
// Supports byte/halfword/word(/dword) writes through byte lanes and
// programmable wait states. Illegal accesses get the two-cycle ERROR response.
//
// Ports:
//   hclk, hresten          clock, synchronous active-high reset
//   hsel, haddr, htrans,   AHB-Lite address phase
//   hwrite, hsize, hburst,
//   hprot, hmastlock, hready
//   hwdata                 write data (data phase)
//   hrdata                 read data, combinational from the array in a read data phase
//   hreadyout, hresp       slave handshake, decoded from the FSM state
module ahb_lite_sram_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresten,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp
);

    localparam int unsigned LANES     = DATA_W / 8;
    localparam int unsigned OFF_W     = $clog2(LANES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = 4;
    localparam logic [ADDR_W:0]  MEM_BYTES = (ADDR_W+1)'(DEPTH * LANES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [OFF_W-1:0]   off_q;
    logic [2:0]         size_q;
    logic               write_q;

    logic               accept_c;
    logic               illegal_c;
    logic               open_c;
    logic               capture_c;
    logic               commit_c;
    logic [LANES-1:0]   lane_mask_c;
    logic [LANES-1:0]   be_c;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Bus inputs carried only for protocol completeness.
    logic unused;
    assign unused = &{1'b0, hburst, hprot, hmastlock, htrans[0], haddr};

    assign accept_c = hsel & hready & htrans[1];

    // Out-of-range, oversize or misaligned accesses take the ERROR path.
    always_comb begin
        logic oob;
        logic bad_size;
        logic misalign;
        oob      = {1'b0, haddr} >= MEM_BYTES;
        bad_size = 32'(hsize) > OFF_W;
        misalign = 1'b0;
        case (hsize)
            3'd0:    misalign = 1'b0;
            3'd1:    misalign = haddr[0];
            3'd2:    misalign = |haddr[1:0];
            3'd3:    misalign = |haddr[2:0];
            default: misalign = 1'b1;
        endcase
        illegal_c = oob | bad_size | misalign;
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (hresten) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and handshake outputs; open_c marks cycles that may take a new address phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        open_c    = 1'b0;
        capture_c = 1'b0;
        commit_c  = 1'b0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            S_IDLE: begin
                open_c = 1'b1;
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    hreadyout = 1'b0;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    commit_c = write_q;
                    open_c   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                open_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (open_c && accept_c) begin
            capture_c = 1'b1;
            if (illegal_c) begin
                state_d = S_ERR1;
            end else begin
                state_d = S_DATA;
                cnt_d   = WAIT_LOAD;
            end
        end
    end

    // Address-phase capture.
    always_ff @(posedge hclk) begin
        if (hresten) begin
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else if (capture_c) begin
            idx_q   <= haddr[OFF_W +: IDX_W];
            off_q   <= haddr[OFF_W-1:0];
            size_q  <= hsize;
            write_q <= hwrite;
        end
    end

    // Byte-lane enables from size and lane offset.
    always_comb begin
        lane_mask_c = '0;
        case (size_q)
            3'd0:    lane_mask_c = LANES'(1);
            3'd1:    lane_mask_c = LANES'(3);
            3'd2:    lane_mask_c = LANES'(15);
            default: lane_mask_c = '1;
        endcase
        be_c = lane_mask_c << off_q;
    end

    // Writes commit on the completing edge; a reset on that edge drops them.
    always_ff @(posedge hclk) begin
        if (commit_c && !hresten) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (be_c[b]) begin
                    mem[idx_q][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    assign hrdata = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: one instance with 0 wait states, one with 3.
// Shared address/data bus, per-instance hsel; each instance's hready is its own hreadyout.
module tb_ahb_lite_sram_slave;

    logic        hclk = 1'b0;
    logic        hresten;
    logic [1:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [1:0]  rdy;
    logic [1:0]  rsp;
    logic [31:0] rd0, rd1;

    int vecs = 0;
    int miscomp = 0;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
        .hclk(hclk), .hresten(hresten), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd3), .hmastlock(1'b0),
        .hready(rdy[0]), .hwdata(hwdata), .hrdata(rd0), .hreadyout(rdy[0]), .hresp(rsp[0])
    );

    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3)) dut_ws3 (
        .hclk(hclk), .hresten(hresten), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd3), .hmastlock(1'b0),
        .hready(rdy[1]), .hwdata(hwdata), .hrdata(rd1), .hreadyout(rdy[1]), .hresp(rsp[1])
    );

    typedef struct {
        int          d;      // 0 = WS0 instance, 1 = WS3 instance
        bit          w;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(int d, bit w, logic [31:0] a, logic [2:0] s,
                                logic [31:0] wd, bit e, logic [31:0] rdv, int wt);
        vec_t v;
        v.d = d; v.w = w; v.addr = a; v.size = s; v.wdata = wd;
        v.err = e; v.rdata = rdv; v.waits = wt;
        return v;
    endfunction

    function automatic logic [31:0] rdata_of(int d);
        return (d == 1) ? rd1 : rd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge where the target is ready; returns at the negedge of the
    // cycle that completes the transfer, so back-to-back calls pipeline.
    task automatic xfer(input vec_t v, input int n);
        int waits;
        hsel = '0;
        hsel[v.d] = 1'b1;
        haddr  = v.addr;
        htrans = 2'b10;
        hwrite = v.w;
        hsize  = v.size;
        @(negedge hclk);
        hsel   = '0;
        htrans = 2'b00;
        hwdata = v.wdata;
        if (v.err) begin
            check($sformatf("v%0d_err1_ready", n), 32'(rdy[v.d]), 32'd0);
            check($sformatf("v%0d_err1_resp", n), 32'(rsp[v.d]), 32'd1);
            @(negedge hclk);
            check($sformatf("v%0d_err2_ready", n), 32'(rdy[v.d]), 32'd1);
            check($sformatf("v%0d_err2_resp", n), 32'(rsp[v.d]), 32'd1);
        end else begin
            waits = 0;
            while (!rdy[v.d] && waits < 20) begin
                waits++;
                @(negedge hclk);
            end
            check($sformatf("v%0d_waits", n), 32'(waits), 32'(v.waits));
            check($sformatf("v%0d_resp", n), 32'(rsp[v.d]), 32'd0);
            check($sformatf("v%0d_rdata", n), rdata_of(v.d), v.w ? 32'd0 : v.rdata);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 32'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0,        0);
        tbl[1]  = mk(0, 0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF, 0);
        tbl[2]  = mk(0, 1, 32'h020, 3'd2, 32'h00000000, 0, 32'h0,        0);
        tbl[3]  = mk(0, 1, 32'h021, 3'd0, 32'h00001100, 0, 32'h0,        0);
        tbl[4]  = mk(0, 1, 32'h022, 3'd1, 32'hAABB0000, 0, 32'h0,        0);
        tbl[5]  = mk(0, 0, 32'h020, 3'd2, 32'h0,        0, 32'hAABB1100, 0);
        tbl[6]  = mk(0, 0, 32'h1000, 3'd2, 32'h0,       1, 32'h0,        0);
        tbl[7]  = mk(0, 0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF, 0);
        tbl[8]  = mk(0, 1, 32'h030, 3'd2, 32'hCAFEF00D, 0, 32'h0,        0);
        tbl[9]  = mk(0, 1, 32'h031, 3'd1, 32'hFFFFFFFF, 1, 32'h0,        0);
        tbl[10] = mk(0, 0, 32'h030, 3'd2, 32'h0,        0, 32'hCAFEF00D, 0);
        tbl[11] = mk(0, 1, 32'h038, 3'd3, 32'hFFFFFFFF, 1, 32'h0,        0);
        tbl[12] = mk(0, 0, 32'h030, 3'd2, 32'h0,        0, 32'hCAFEF00D, 0);
        tbl[13] = mk(0, 1, 32'h034, 3'd2, 32'h01020304, 0, 32'h0,        0);
        tbl[14] = mk(0, 0, 32'h035, 3'd0, 32'h0,        0, 32'h01020304, 0);
        tbl[15] = mk(0, 1, 32'hFFC, 3'd2, 32'h55AA55AA, 0, 32'h0,        0);
        tbl[16] = mk(0, 0, 32'hFFC, 3'd2, 32'h0,        0, 32'h55AA55AA, 0);
        tbl[17] = mk(1, 1, 32'h040, 3'd2, 32'h12345678, 0, 32'h0,        3);
        tbl[18] = mk(1, 0, 32'h040, 3'd2, 32'h0,        0, 32'h12345678, 3);
        tbl[19] = mk(1, 0, 32'h1000, 3'd2, 32'h0,       1, 32'h0,        0);

        hresten = 1'b1;
        hsel    = '0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd2;
        hwdata  = '0;
        repeat (2) @(negedge hclk);
        check("rst_ready", 32'(rdy), 32'h3);
        check("rst_resp", 32'(rsp), 32'h0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_rdata1", rd1, 32'h0);
        hresten = 1'b0;
        @(negedge hclk);

        for (int i = 0; i < NV; i++) begin
            xfer(tbl[i], i);
        end

        // Legal read straight after the ERR2 cycle on the wait-state instance.
        xfer(mk(1, 0, 32'h040, 3'd2, 32'h0, 0, 32'h12345678, 3), 100);

        // Reset during the second wait cycle of a write abandons it.
        hsel   = 2'b10;
        haddr  = 32'h040;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(negedge hclk);
        hsel   = '0;
        htrans = 2'b00;
        hwdata = 32'hFFFFFFFF;
        check("rstw_wait1_ready", 32'(rdy[1]), 32'd0);
        @(negedge hclk);
        check("rstw_wait2_ready", 32'(rdy[1]), 32'd0);
        hresten = 1'b1;
        @(negedge hclk);
        hresten = 1'b0;
        check("rstw_after_ready", 32'(rdy[1]), 32'd1);
        check("rstw_after_resp", 32'(rsp[1]), 32'd0);
        check("rstw_after_rdata", rd1, 32'd0);
        xfer(mk(1, 0, 32'h040, 3'd2, 32'h0, 0, 32'h12345678, 3), 101);

        @(negedge hclk);
        check("end_idle_ready", 32'(rdy), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
        $finish;
    end

endmodule
